// File: rtl/axi_resp_pkg.sv
// ---------------------------------------------------------------------------
// axi_resp_pkg
//   Shared AXI write-response definitions for the crossbar return path.
//   Contents:
//     OKAY, EXOKAY, SLVERR, DECERR  - BRESP encodings
//     is_err_resp(resp)             - 1 when the response reports an error
// ---------------------------------------------------------------------------
package axi_resp_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // SLVERR and DECERR share the upper bit, so the error test is one bit.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/b_resp_collector_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. The search begins at index ptr
//   and wraps modulo N; the first requesting index wins.
//   Ports:
//     req        in   N      request vector
//     ptr        in   PTR_W  index where the search starts
//     grant      out  N      one-hot grant (all zero when nothing requests)
//     grant_idx  out  PTR_W  index of the granted requester (0 if none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic found;
  int   idx;

  // Walk the requesters in rotated order starting at ptr and lock onto the
  // first one asserting req. With N=1 this collapses to grant = req.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/b_resp_collector.sv
// ---------------------------------------------------------------------------
// b_resp_collector
//   Collects AXI B-channel responses from N_SLAVES slave ports with
//   round-robin arbitration, holds the winner in a one-entry stage and pushes
//   {BID, BRESP} into the downstream write-response FIFO. Keeps a saturating
//   count of error responses for debug.
//   Ports:
//     ACLK        in   1                    clock, rising edge
//     ARESET      in   1                    synchronous reset, active-high
//     S_BVALID    in   N_SLAVES             per-slave response valid
//     S_BID       in   N_SLAVES*ID_WIDTH    per-slave BID, slave k at [k*ID_WIDTH +: ID_WIDTH]
//     S_BRESP     in   N_SLAVES*2           per-slave BRESP, slave k at [k*2 +: 2]
//     S_BREADY    out  N_SLAVES             per-slave ready, at most one bit high
//     push        out  1                    push strobe to the response FIFO
//     full        in   1                    response FIFO full
//     push_BID    out  ID_WIDTH             BID presented with push
//     push_BRESP  out  2                    BRESP presented with push
//     err_count   out  ERR_CNT_WIDTH        saturating count of SLVERR/DECERR
// ---------------------------------------------------------------------------
module b_resp_collector
  import axi_resp_pkg::*;
#(
  parameter int ID_WIDTH      = 4,
  parameter int N_SLAVES      = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [N_SLAVES-1:0]          S_BVALID,
  input  logic [N_SLAVES*ID_WIDTH-1:0] S_BID,
  input  logic [N_SLAVES*2-1:0]        S_BRESP,
  output logic [N_SLAVES-1:0]          S_BREADY,
  output logic                         push,
  input  logic                         full,
  output logic [ID_WIDTH-1:0]          push_BID,
  output logic [1:0]                   push_BRESP,
  output logic [ERR_CNT_WIDTH-1:0]     err_count
);

  localparam int PTR_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  logic                hold_valid;
  logic [ID_WIDTH-1:0] hold_BID;
  logic [1:0]          hold_BRESP;
  logic [PTR_W-1:0]    rr_ptr;

  logic [N_SLAVES-1:0] grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_any;
  logic                can_accept;
  logic                handshake;
  logic [ID_WIDTH-1:0] sel_BID;
  logic [1:0]          sel_BRESP;
  logic [PTR_W-1:0]    next_ptr;

  rr_arbiter #(
    .N     (N_SLAVES),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (S_BVALID),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Push and ready are both masked while ARESET is high: the holding stage is
  // about to be cleared, so a held entry must not leak into the FIFO and no
  // slave may see a handshake that the reset edge would throw away.
  // can_accept includes push so the stage can drain and refill in one cycle.
  always_comb begin
    push       = hold_valid & ~full & ~ARESET;
    can_accept = (~hold_valid | push) & ~ARESET;
    grant_any  = |grant;
    handshake  = can_accept & grant_any;
    S_BREADY   = can_accept ? grant : '0;
    sel_BID    = S_BID[grant_idx*ID_WIDTH +: ID_WIDTH];
    sel_BRESP  = S_BRESP[grant_idx*2 +: 2];
    next_ptr   = (grant_idx == PTR_W'(N_SLAVES - 1)) ? '0 : grant_idx + 1'b1;
  end

  assign push_BID   = hold_BID;
  assign push_BRESP = hold_BRESP;

  // Holding stage and arbitration pointer. A new handshake always wins over a
  // drain, since a handshake in the same cycle as a push is a refill.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      hold_valid <= 1'b0;
      hold_BID   <= '0;
      hold_BRESP <= '0;
      rr_ptr     <= '0;
    end else if (handshake) begin
      hold_valid <= 1'b1;
      hold_BID   <= sel_BID;
      hold_BRESP <= sel_BRESP;
      rr_ptr     <= next_ptr;
    end else if (push) begin
      hold_valid <= 1'b0;
    end
  end

  // Error counter sticks at all-ones rather than wrapping so a long-running
  // debug read never under-reports.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_count <= '0;
    end else if (handshake && is_err_resp(sel_BRESP) && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_b_resp_collector.sv
// ---------------------------------------------------------------------------
// tb_b_resp_collector
//   Directed bench for b_resp_collector. Expected pushes are queued when a
//   handshake is stimulated; a monitor pops and compares whenever push is
//   high. A second instance with a 2-bit error counter shares the stimulus.
// ---------------------------------------------------------------------------
module tb_b_resp_collector;
  import axi_resp_pkg::*;

  logic        ACLK;
  logic        ARESET;
  logic [3:0]  S_BVALID;
  logic [15:0] S_BID;
  logic [7:0]  S_BRESP;
  logic [3:0]  S_BREADY;
  logic        push;
  logic        full;
  logic [3:0]  push_BID;
  logic [1:0]  push_BRESP;
  logic [15:0] err_count;

  logic [3:0]  small_BREADY;
  logic        small_push;
  logic [3:0]  small_BID;
  logic [1:0]  small_BRESP;
  logic [1:0]  small_err_count;

  logic [3:0]  bidTab  [4];
  logic [1:0]  respTab [4];
  logic [5:0]  expQ    [$];

  int errors = 0;
  int checks = 0;

  b_resp_collector #(.ID_WIDTH(4), .N_SLAVES(4), .ERR_CNT_WIDTH(16)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .S_BVALID   (S_BVALID),
    .S_BID      (S_BID),
    .S_BRESP    (S_BRESP),
    .S_BREADY   (S_BREADY),
    .push       (push),
    .full       (full),
    .push_BID   (push_BID),
    .push_BRESP (push_BRESP),
    .err_count  (err_count)
  );

  b_resp_collector #(.ID_WIDTH(4), .N_SLAVES(4), .ERR_CNT_WIDTH(2)) dut_small (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .S_BVALID   (S_BVALID),
    .S_BID      (S_BID),
    .S_BRESP    (S_BRESP),
    .S_BREADY   (small_BREADY),
    .push       (small_push),
    .full       (full),
    .push_BID   (small_BID),
    .push_BRESP (small_BRESP),
    .err_count  (small_err_count)
  );

  // 100 MHz-style free-running clock
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive after the rising edge, queue any expected
  // handshake, then check ready and push on the falling edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic fullIn,
                               input logic [3:0] expReady, input logic expPush);
    @(posedge ACLK);
    #1;
    ARESET   = rst;
    S_BVALID = valid;
    full     = fullIn;
    for (int k = 0; k < 4; k++) begin
      S_BID[k*4 +: 4]   = bidTab[k];
      S_BRESP[k*2 +: 2] = respTab[k];
    end
    if (rst) expQ.delete();
    for (int k = 0; k < 4; k++)
      if (expReady[k]) expQ.push_back({bidTab[k], respTab[k]});
    @(negedge ACLK);
    checkOutput("S_BREADY", 32'(S_BREADY), 32'(expReady));
    checkOutput("push", 32'(push), 32'(expPush));
  endtask

  // Scoreboard monitor: each push must match the oldest queued response
  always @(negedge ACLK) begin
    if (push === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL pushData: got %0h with nothing expected at %0t", {push_BID, push_BRESP}, $time);
      end else begin
        logic [5:0] e;
        e = expQ.pop_front();
        if ({push_BID, push_BRESP} !== e) begin
          errors++;
          $display("[TB] FAIL pushData: got %0h expected %0h at %0t", {push_BID, push_BRESP}, e, $time);
        end
      end
    end
  end

  initial begin
    ARESET   = 1'b1;
    S_BVALID = 4'b1111;
    full     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bidTab[k]  = 4'(k);
      respTab[k] = OKAY;
    end
    S_BID   = '0;
    S_BRESP = '0;

    // Reset held with all slaves requesting
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
    checkOutput("resetErr", 32'(err_count), 32'd0);
    checkOutput("resetBid", 32'(push_BID), 32'd0);

    // Round robin 0,1,2,3,0 with one-cycle push latency
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Move rr_ptr to 3, then skip and wrap onto slaves 1 and 2
    applyStimulus(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b0110, 1'b0, 4'b0010, 1'b1);
    applyStimulus(1'b0, 4'b0110, 1'b0, 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Backpressure: BID 5 from slave 2 held through five full cycles
    bidTab[2] = 4'd5;
    applyStimulus(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0);
      checkOutput("stallBid", 32'(push_BID), 32'd5);
    end
    applyStimulus(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    bidTab[2] = 4'd2;

    // Error counter: OKAY, SLVERR, EXOKAY, DECERR from slaves 3,0,1,2
    respTab[3] = OKAY;
    respTab[0] = SLVERR;
    respTab[1] = EXOKAY;
    respTab[2] = DECERR;
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    checkOutput("errCount", 32'(err_count), 32'd2);
    checkOutput("errCountSmall", 32'(small_err_count), 32'd2);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Five more SLVERRs: wide counter reaches 7, 2-bit counter sticks at 3
    for (int k = 0; k < 4; k++) respTab[k] = SLVERR;
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1);
    checkOutput("errSmallSat1", 32'(small_err_count), 32'd3);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    checkOutput("errCountWide", 32'(err_count), 32'd7);
    checkOutput("errSmallSat", 32'(small_err_count), 32'd3);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Reset while an entry is held behind full: it must never be pushed
    applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
    checkOutput("errBeforeReset", 32'(err_count), 32'd8);
    applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    checkOutput("errAfterReset", 32'(err_count), 32'd0);
    checkOutput("errSmallAfterReset", 32'(small_err_count), 32'd0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // rr_ptr restarts at slave 0 after reset
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/b_resp_collector.md
Name: b_resp_collector

Overview:
- Upstream neighbour of the write-response FIFO in the crossbar return path.
- Gathers AXI B-channel responses from N_SLAVES slave ports using round-robin arbitration.
- Registers the winning response in a one-entry holding stage, then pushes {BID, BRESP} into the response FIFO through its push/full interface.
- Also keeps a saturating count of error responses (SLVERR/DECERR) for debug.

Parameters:
- ID_WIDTH, 4, width of BID on every port.
- N_SLAVES, 4, number of slave-side B channels; legal range 1..16.
- ERR_CNT_WIDTH, 16, width of the error counter.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous reset, active-high.
- S_BVALID  in  N_SLAVES  per-slave response valid.
- S_BID  in  N_SLAVES*ID_WIDTH  per-slave BID; slave k occupies bits [k*ID_WIDTH +: ID_WIDTH].
- S_BRESP  in  N_SLAVES*2  per-slave BRESP; slave k occupies bits [k*2 +: 2].
- S_BREADY  out  N_SLAVES  per-slave ready; at most one bit high per cycle.
- push  out  1  push strobe to response FIFO.
- full  in  1  response FIFO full.
- push_BID  out  ID_WIDTH  BID presented with push.
- push_BRESP  out  2  BRESP presented with push.
- err_count  out  ERR_CNT_WIDTH  number of accepted responses with BRESP[1]=1.

Behaviour:
- Reset: takes effect only on a rising ACLK edge with ARESET=1. It clears:
  - hold_valid to 0;
  - hold_BID and hold_BRESP to 0;
  - rr_ptr to 0;
  - err_count to 0.
  - After reset, S_BREADY, push, push_BID and push_BRESP all read 0.
- Reset mid-operation: any response in the holding stage is discarded, not pushed. Slaves see no handshake for it.
- push = hold_valid & ~full. push_BID = hold_BID, push_BRESP = hold_BRESP; both are direct register outputs.
- The FIFO ignores push while full. The block therefore never asserts push while full is high and keeps the entry held.
- can_accept = ~hold_valid | push. This gives same-cycle drain-and-refill, so sustained throughput is one response per cycle.
- Arbitration:
  - Combinational round-robin over S_BVALID.
  - Search starts at index rr_ptr and wraps modulo N_SLAVES; the first valid index is the grant g.
  - No request means no grant.
- S_BREADY[g] = can_accept & (a grant exists); all other bits are 0.
- S_BREADY may depend combinationally on S_BVALID, as AXI permits. It is never registered.
- On a handshake (S_BVALID[g] & S_BREADY[g]) at edge t:
  - hold_BID and hold_BRESP load slave g's fields;
  - hold_valid is set to 1;
  - rr_ptr is set to (g+1) mod N_SLAVES, wrapping from N_SLAVES-1 to 0.
- Latency: a response accepted at edge t appears on push starting at t+1 if full=0.
- If a push occurs with no new handshake, hold_valid clears at the edge.
- The held entry stays stable while full=1. Stall duration is unbounded; no timeout.
- err_count increments by 1 on each handshake with BRESP[1]=1 (SLVERR or DECERR). It saturates at all-ones and does not wrap.
- N_SLAVES=1: rr_ptr is a 1-bit register held at 0, and the arbiter reduces to a pass-through.
- No ID remapping: BID passes through unchanged.

Decomposition:
- Package axi_resp_pkg holds:
  - BRESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the function is_err_resp(resp), returning resp[1].
- One sub-module, rr_arbiter, parameterised on N:
  - inputs: req vector and ptr;
  - outputs: one-hot grant and grant index.
  - It is purely combinational; rr_ptr lives in b_resp_collector.

Test Plan:
- Reset: hold ARESET high with S_BVALID=4'b1111 -> S_BREADY=0, push=0, err_count=0. First release cycle: S_BREADY=4'b0001.
- Round-robin: S_BVALID=4'b1111 held, full=0, S_BID[k]=k -> grants 0,1,2,3,0 on consecutive cycles. push_BID sequence is 0,1,2,3,0, each one cycle after its grant, with push=1 every cycle.
- Skip and wrap: rr_ptr=3, S_BVALID=4'b0110 -> grant slave 1 (S_BREADY=4'b0010), then slave 2, then no grant once S_BVALID drops.
- Backpressure:
  - Accept BID=5 from slave 2, then raise full for 5 cycles -> push=0 throughout, push_BID stays 5, S_BREADY=0 while the entry is held.
  - Drop full -> push=1 with BID=5 in that cycle, and S_BREADY reasserts in the same cycle.
- Error counter: accept BRESP sequence OKAY, SLVERR, EXOKAY, DECERR -> err_count=2. With ERR_CNT_WIDTH=2, push 5 SLVERRs -> err_count stays 3.
- Reset mid-operation: hold_valid=1 with full=1, assert ARESET for one cycle -> push=0 and err_count=0 next cycle. The held response never appears on push.
